conv_mac_sequencer: RTL and testbench

//  Sequences one shared MAC PE over a valid-mode 2-D convolution (IMG x IMG image, K x K filter).

---
 rtl/conv_mac_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// Sequencer driving one shared MAC PE over a valid-mode IMG x IMG / K x K convolution.
// Optional busy-cycle counter on cyc_cnt enabled by defining SEQ_PERF_CNT_EN.
module conv_mac_sequencer #(
  parameter int DW  = 8,
  parameter int IMG = 4,
  parameter int K   = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            mem_re,
  output logic [((IMG*IMG > 1) ? $clog2(IMG*IMG) : 1)-1:0] img_addr,
  output logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0]         flt_addr,
  output logic                                            pe_vld,
  output logic                                            pe_first,
  output logic                                            pe_last,
  input  logic                                            pe_res_vld,
  input  logic [DW-1:0]                                   pe_res,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [(((IMG-K+1)*(IMG-K+1) > 1) ? $clog2((IMG-K+1)*(IMG-K+1)) : 1)-1:0] out_idx,
  output logic [DW-1:0]                                   out_data,
  output logic [15:0]                                     cyc_cnt
);
  localparam int OUT = IMG - K + 1;
  localparam int IAW = (IMG*IMG > 1) ? $clog2(IMG*IMG) : 1;
  localparam int FAW = (K*K > 1) ? $clog2(K*K) : 1;
  localparam int OAW = (OUT*OUT > 1) ? $clog2(OUT*OUT) : 1;
  localparam int CW  = $clog2(IMG + 1);
  localparam logic [CW-1:0] KM1  = CW'(K - 1);
  localparam logic [CW-1:0] OM1  = CW'(OUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_r, state_s;
  logic [CW-1:0] orow_r, ocol_r, kr_r, kc_r;
  logic [CW-1:0] orow_s, ocol_s, kr_s, kc_s;
  logic busy_r, done_r, mem_re_r, tap_first_r, tap_last_r;
  logic pe_vld_r, pe_first_r, pe_last_r, out_valid_r;
  logic [IAW-1:0] img_addr_r;
  logic [FAW-1:0] flt_addr_r;
  logic [OAW-1:0] out_idx_r;
  logic [DW-1:0]  out_data_r;
  logic           run_s;

  function automatic logic [IAW-1:0] img_addr_f(input logic [CW-1:0] orow, ocol, kr, kc);
    return IAW'((32'(orow) + 32'(kr)) * 32'(IMG) + 32'(ocol) + 32'(kc));
  endfunction

  function automatic logic [FAW-1:0] flt_addr_f(input logic [CW-1:0] kr, kc);
    return FAW'(32'(kr) * 32'(K) + 32'(kc));
  endfunction

  function automatic logic [OAW-1:0] out_idx_f(input logic [CW-1:0] orow, ocol);
    return OAW'(32'(orow) * 32'(OUT) + 32'(ocol));
  endfunction

  // Next-state and tap/pixel counter advance; kc inner, kr outer, ocol inner, orow outer
  always_comb begin
    state_s = state_r;
    orow_s  = orow_r;
    ocol_s  = ocol_r;
    kr_s    = kr_r;
    kc_s    = kc_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (kc_r == KM1) begin
          kc_s = ZERO;
          if (kr_r == KM1) begin
            kr_s    = ZERO;
            state_s = WAIT;
          end else begin
            kr_s = kr_r + ONE;
          end
        end else begin
          kc_s = kc_r + ONE;
        end
      end
      WAIT: begin
        if (pe_res_vld) state_s = WRITE;
        else            state_s = WAIT;
      end
      WRITE: begin
        if (out_ready) begin
          if (ocol_r == OM1) begin
            ocol_s = ZERO;
            if (orow_r == OM1) begin
              orow_s  = ZERO;
              state_s = DONE;
            end else begin
              orow_s  = orow_r + ONE;
              state_s = RUN;
            end
          end else begin
            ocol_s  = ocol_r + ONE;
            state_s = RUN;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE: state_s = IDLE;
      default: begin
        state_s = IDLE;
        orow_s  = ZERO;
        ocol_s  = ZERO;
        kr_s    = ZERO;
        kc_s    = ZERO;
      end
    endcase
    run_s = (state_s == RUN);
  end

  // State and counters; outputs are registered from the next-state view so they align with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      orow_r      <= ZERO;
      ocol_r      <= ZERO;
      kr_r        <= ZERO;
      kc_r        <= ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_re_r    <= 1'b0;
      img_addr_r  <= {IAW{1'b0}};
      flt_addr_r  <= {FAW{1'b0}};
      tap_first_r <= 1'b0;
      tap_last_r  <= 1'b0;
      pe_vld_r    <= 1'b0;
      pe_first_r  <= 1'b0;
      pe_last_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      orow_r      <= orow_s;
      ocol_r      <= ocol_s;
      kr_r        <= kr_s;
      kc_r        <= kc_s;
      busy_r      <= (state_s == RUN) || (state_s == WAIT) || (state_s == WRITE);
      done_r      <= (state_s == DONE);
      mem_re_r    <= run_s;
      img_addr_r  <= run_s ? img_addr_f(orow_s, ocol_s, kr_s, kc_s) : {IAW{1'b0}};
      flt_addr_r  <= run_s ? flt_addr_f(kr_s, kc_s) : {FAW{1'b0}};
      tap_first_r <= run_s && (kr_s == ZERO) && (kc_s == ZERO);
      tap_last_r  <= run_s && (kr_s == KM1) && (kc_s == KM1);
      pe_vld_r    <= mem_re_r;
      pe_first_r  <= tap_first_r;
      pe_last_r   <= tap_last_r;
      out_valid_r <= (state_s == WRITE);
    end
  end

  // Result capture; held stable through WRITE until the sink accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r <= {DW{1'b0}};
      out_idx_r  <= {OAW{1'b0}};
    end else if ((state_r == WAIT) && pe_res_vld) begin
      out_data_r <= pe_res;
      out_idx_r  <= out_idx_f(orow_r, ocol_r);
    end else begin
      out_data_r <= out_data_r;
      out_idx_r  <= out_idx_r;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cyc_cnt_r;

  // Busy-cycle counter: cleared on accepted start, saturating, held after done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_r <= 16'd0;
    end else if ((state_r == IDLE) && start) begin
      cyc_cnt_r <= 16'd0;
    end else if (busy_r && (cyc_cnt_r != 16'hFFFF)) begin
      cyc_cnt_r <= cyc_cnt_r + 16'd1;
    end else begin
      cyc_cnt_r <= cyc_cnt_r;
    end
  end

  assign cyc_cnt = cyc_cnt_r;
`else
  assign cyc_cnt = 16'd0;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_re    = mem_re_r;
  assign img_addr  = img_addr_r;
  assign flt_addr  = flt_addr_r;
  assign pe_vld    = pe_vld_r;
  assign pe_first  = pe_first_r;
  assign pe_last   = pe_last_r;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer: model memories plus a latency-1 MAC PE.
module tb_conv_mac_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_re, pe_vld, pe_first, pe_last;
  logic [3:0]  img_addr;
  logic [3:0]  flt_addr;
  logic        pe_res_vld = 1'b0;
  logic [7:0]  pe_res = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_idx;
  logic [7:0]  out_data;
  logic [15:0] cyc_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  int img_mem [16] = '{8,3,9,1, 7,7,2,8, 5,6,3,1, 4,9,2,6};
  int flt_mem [9]  = '{1,5,8, 6,0,7, 3,1,2};
  int exp_data [4] = '{178, 177, 134, 165};
  int exp_p1 [9]   = '{1,2,3, 5,6,7, 9,10,11};
  int img_q = 0, flt_q = 0, acc = 0;

  int res_data[$], res_idx[$], rd_img[$], rd_flt[$], tap_first[$], tap_last[$];
  int done_cnt, done_cyc, busy_first, busy_last, busy_n, stall_seen, stall_bad;

  conv_mac_sequencer #(.DW(8), .IMG(4), .K(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_re(mem_re), .img_addr(img_addr), .flt_addr(flt_addr),
    .pe_vld(pe_vld), .pe_first(pe_first), .pe_last(pe_last),
    .pe_res_vld(pe_res_vld), .pe_res(pe_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand memories feeding a one-cycle-latency MAC PE
  always @(posedge clk) begin
    if (mem_re) begin
      img_q <= img_mem[int'(img_addr)];
      flt_q <= flt_mem[int'(flt_addr)];
    end
    pe_res_vld <= 1'b0;
    if (pe_vld) begin
      acc <= (pe_first ? 0 : acc) + img_q * flt_q;
      if (pe_last) begin
        pe_res_vld <= 1'b1;
        pe_res     <= 8'((pe_first ? 0 : acc) + img_q * flt_q);
      end
    end
  end

  // Drives one convolution from cycle 0 and records what the DUT does; no checking here
  task automatic run_conv(input int ncyc, input int stall_idx, input int stall_len,
                          input logic [7:0] stall_val, input int poke_cyc);
    int stall_n;
    stall_n = 0;
    res_data.delete(); res_idx.delete(); rd_img.delete(); rd_flt.delete();
    tap_first.delete(); tap_last.delete();
    done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1; busy_n = 0;
    stall_seen = 0; stall_bad = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == poke_cyc || c == poke_cyc + 1) ? 1'b1 : 1'b0;
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_n++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (mem_re) begin
        rd_img.push_back(int'(img_addr));
        rd_flt.push_back(int'(flt_addr));
      end
      if (pe_vld) begin
        tap_first.push_back(int'(pe_first));
        tap_last.push_back(int'(pe_last));
      end
      if (out_valid && int'(out_idx) == stall_idx && stall_n < stall_len) begin
        out_ready = 1'b0;
        stall_n++;
        stall_seen++;
        if (out_data !== stall_val || mem_re !== 1'b0 || out_valid !== 1'b1) stall_bad++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        res_data.push_back(int'(out_data));
        res_idx.push_back(int'(out_idx));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({busy, done, mem_re, pe_vld, pe_first, pe_last, out_valid} !== 7'd0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, mem_re, pe_vld, pe_first, pe_last, out_valid});
    end
    vec_cnt++;
    if ({img_addr, flt_addr, out_idx, out_data, cyc_cnt} !== 34'd0) begin
      err_cnt++;
      $display("FAIL reset_data: img_addr=%0d flt_addr=%0d out_idx=%0d out_data=%0d cyc_cnt=%0d want all 0",
               img_addr, flt_addr, out_idx, out_data, cyc_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int nf, nl;
    run_conv(60, -1, 0, 8'd0, -10);
    vec_cnt++;
    if (res_data.size() !== 4) begin
      err_cnt++;
      $display("FAIL basic_count: got %0d transfers want 4", res_data.size());
    end
    for (int i = 0; i < 4 && i < res_data.size(); i++) begin
      vec_cnt++;
      if (res_data[i] !== exp_data[i] || res_idx[i] !== i) begin
        err_cnt++;
        $display("FAIL basic_result[%0d]: got data=%0d idx=%0d want data=%0d idx=%0d",
                 i, res_data[i], res_idx[i], exp_data[i], i);
      end
    end
    vec_cnt++;
    if (busy_first !== 1 || busy_last !== 48 || busy_n !== 48) begin
      err_cnt++;
      $display("FAIL basic_busy: got first=%0d last=%0d n=%0d want 1,48,48", busy_first, busy_last, busy_n);
    end
    vec_cnt++;
    if (done_cyc !== 49 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL basic_done: got cycle=%0d pulses=%0d want 49,1", done_cyc, done_cnt);
    end
    vec_cnt++;
    if (rd_img.size() !== 36 || tap_first.size() !== 36) begin
      err_cnt++;
      $display("FAIL basic_reads: got reads=%0d taps=%0d want 36,36", rd_img.size(), tap_first.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        vec_cnt++;
        if (rd_img[9+j] !== exp_p1[j] || rd_flt[9+j] !== j) begin
          err_cnt++;
          $display("FAIL p1_addr[%0d]: got img=%0d flt=%0d want img=%0d flt=%0d",
                   j, rd_img[9+j], rd_flt[9+j], exp_p1[j], j);
        end
        vec_cnt++;
        if (tap_first[9+j] !== (j == 0 ? 1 : 0) || tap_last[9+j] !== (j == 8 ? 1 : 0)) begin
          err_cnt++;
          $display("FAIL p1_tapflag[%0d]: got first=%0d last=%0d", j, tap_first[9+j], tap_last[9+j]);
        end
      end
      nf = 0; nl = 0;
      for (int j = 0; j < 36; j++) begin
        nf += tap_first[j];
        nl += tap_last[j];
      end
      vec_cnt++;
      if (nf !== 4 || nl !== 4) begin
        err_cnt++;
        $display("FAIL tapflag_total: got first=%0d last=%0d want 4,4", nf, nl);
      end
    end
    vec_cnt++;
`ifdef SEQ_PERF_CNT_EN
    if (cyc_cnt !== 16'd48) begin
      err_cnt++;
      $display("FAIL cyc_cnt: got %0d want 48", cyc_cnt);
    end
`else
    if (cyc_cnt !== 16'd0) begin
      err_cnt++;
      $display("FAIL cyc_cnt: got %0d want 0", cyc_cnt);
    end
`endif
  endtask

  task automatic test_backpressure;
    run_conv(70, 2, 5, 8'd134, -10);
    vec_cnt++;
    if (stall_seen !== 5 || stall_bad !== 0) begin
      err_cnt++;
      $display("FAIL stall_hold: got stalled=%0d bad=%0d want 5,0", stall_seen, stall_bad);
    end
    vec_cnt++;
    if (res_data.size() !== 4) begin
      err_cnt++;
      $display("FAIL stall_count: got %0d transfers want 4", res_data.size());
    end
    for (int i = 0; i < 4 && i < res_data.size(); i++) begin
      vec_cnt++;
      if (res_data[i] !== exp_data[i] || res_idx[i] !== i) begin
        err_cnt++;
        $display("FAIL stall_result[%0d]: got data=%0d idx=%0d want %0d idx %0d",
                 i, res_data[i], res_idx[i], exp_data[i], i);
      end
    end
    vec_cnt++;
    if (done_cyc !== 54 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL stall_done: got cycle=%0d pulses=%0d want 54,1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int nre, ndone, nbusy;
    bit hit;
    nre = 0; hit = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_re) nre++;
      if (nre == 13) hit = 1'b1;
    end
    vec_cnt++;
    if (!hit) begin
      err_cnt++;
      $display("FAIL rstmid_reach: got %0d reads want 13 within 40 cycles", nre);
    end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({busy, done, mem_re, pe_vld, pe_first, pe_last, out_valid, img_addr, flt_addr, out_idx, out_data, cyc_cnt}
        !== 41'd0) begin
      err_cnt++;
      $display("FAIL rstmid_zero: got busy=%b done=%b mem_re=%b pe_vld=%b out_valid=%b img_addr=%0d cyc_cnt=%0d want 0",
               busy, done, mem_re, pe_vld, out_valid, img_addr, cyc_cnt);
    end
    rst = 1'b0;
    ndone = 0; nbusy = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    vec_cnt++;
    if (ndone !== 0 || nbusy !== 0) begin
      err_cnt++;
      $display("FAIL rstmid_quiet: got done=%0d busy=%0d want 0,0", ndone, nbusy);
    end
    run_conv(60, -1, 0, 8'd0, -10);
    vec_cnt++;
    if (res_data.size() !== 4 || res_data[0] !== 178 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL rstmid_restart: got n=%0d first=%0d done=%0d want 4,178,1",
               res_data.size(), (res_data.size() > 0) ? res_data[0] : -1, done_cnt);
    end
  endtask

  task automatic test_start_while_busy;
    run_conv(70, -1, 0, 8'd0, 20);
    vec_cnt++;
    if (res_data.size() !== 4 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL busy_start: got transfers=%0d done=%0d want 4,1", res_data.size(), done_cnt);
    end
    vec_cnt++;
    if (busy_last !== 48 || busy_n !== 48) begin
      err_cnt++;
      $display("FAIL busy_start_len: got last=%0d n=%0d want 48,48", busy_last, busy_n);
    end
    for (int i = 0; i < 4 && i < res_data.size(); i++) begin
      vec_cnt++;
      if (res_data[i] !== exp_data[i]) begin
        err_cnt++;
        $display("FAIL busy_start_result[%0d]: got %0d want %0d", i, res_data[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
